// File: rtl/shuffle_pkg.sv
// Shared types and helpers for the shuffler frame sequencer.
//   state_e   : sequencer states
//   rot_e     : commutator select encodings
//   beat_width: width of the frame beat counter, covers 0..N+2L-1
//   mod_width : width of a modulo-MOD counter (at least one bit)
package shuffle_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ROT0 = 2'd0,
        ROT1 = 2'd1,
        ROT2 = 2'd2
    } rot_e;

    localparam int ROT_COUNT = 3;

    function automatic int beat_width(input int n, input int l);
        return $clog2(n + 2 * l);
    endfunction

    function automatic int mod_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   inc_i  : advance by one
//   clr_i  : return to zero (wins over inc_i)
//   cnt_o  : current count, 0..MOD-1
//   wrap_o : inc_i while at MOD-1 (count returns to zero on this edge)
module mod_counter
    import shuffle_pkg::*;
#(
    parameter int MOD = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      inc_i,
    input  logic                      clr_i,
    output logic [mod_width(MOD)-1:0] cnt_o,
    output logic                      wrap_o
);

    localparam int W = mod_width(MOD);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap_o = inc_i & (cnt_q == W'(MOD - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || wrap_o) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shuffle_ctrl.sv
// Frame sequencer for the 3-parallel data shuffler. Drives the commutator
// select and the delay-buffer advance enable, and produces output framing
// aligned to the 2L-beat buffer latency.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   in_valid_i   : upstream beat present
//   in_sop_i     : first beat of frame (qualified by in_valid_i)
//   in_ready_o   : beat accepted this cycle (low only while draining)
//   buf_en_o     : delay buffers advance one beat
//   sel_o        : commutator rotation 0/1/2, registered
//   out_valid_o  : shuffler output beat valid
//   out_sop_o    : first output beat of frame
//   out_eop_o    : last output beat of frame
//   busy_o       : a frame is in progress
//   err_sop_o    : in_sop_i seen mid-frame (same cycle)
//
// state | meaning
// IDLE  | waiting for sop; non-sop beats are dropped
// FILL  | beats 1..2L-1, buffers filling, no output yet
// RUN   | beats 2L..N-1, input accepted and output valid
// DRAIN | beats N..N+2L-1, input blocked, buffers flushed every cycle
module shuffle_ctrl
    import shuffle_pkg::*;
#(
    parameter int L = 3,
    parameter int N = 27
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    input  logic       in_sop_i,
    output logic       in_ready_o,
    output logic       buf_en_o,
    output logic [1:0] sel_o,
    output logic       out_valid_o,
    output logic       out_sop_o,
    output logic       out_eop_o,
    output logic       busy_o,
    output logic       err_sop_o
);

    localparam int BW    = beat_width(N, L);
    localparam int SEG_W = mod_width(L);

    localparam logic [BW-1:0] FILL_LAST  = BW'(2 * L - 1);
    localparam logic [BW-1:0] RUN_FIRST  = BW'(2 * L);
    localparam logic [BW-1:0] RUN_LAST   = BW'(N - 1);
    localparam logic [BW-1:0] DRAIN_LAST = BW'(N + 2 * L - 1);

    state_e          state_q;
    logic [BW-1:0]   beat_q;
    logic            accept;
    logic            frame_done;
    logic            seg_wrap;
    logic [SEG_W-1:0] seg_cnt;
    logic            sel_wrap;
    logic [1:0]      sel_cnt;
    logic            unused_sig;

    // A non-sop beat in IDLE is dropped rather than advancing the buffers,
    // so the select phase stays locked to the frame start.
    always_comb begin
        accept = 1'b0;
        case (state_q)
            IDLE:      accept = in_valid_i & in_sop_i;
            FILL, RUN: accept = in_valid_i;
            DRAIN:     accept = 1'b1;
            default:   accept = 1'b0;
        endcase
        if (rst_i) begin
            accept = 1'b0;
        end
    end

    assign frame_done  = (state_q == DRAIN) && (beat_q == DRAIN_LAST);

    assign buf_en_o    = accept;
    assign in_ready_o  = rst_i | (state_q != DRAIN);
    assign out_valid_o = accept & (beat_q >= RUN_FIRST);
    assign out_sop_o   = out_valid_o & (beat_q == RUN_FIRST);
    assign out_eop_o   = out_valid_o & (beat_q == DRAIN_LAST);
    assign busy_o      = ~rst_i & (state_q != IDLE);
    assign err_sop_o   = ~rst_i & in_valid_i & in_sop_i &
                         ((state_q == FILL) || (state_q == RUN));
    assign sel_o       = sel_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else if (accept) begin
            beat_q <= frame_done ? '0 : beat_q + 1'b1;
            case (state_q)
                IDLE: state_q <= FILL;
                FILL: begin
                    if (beat_q == FILL_LAST) begin
                        // With N = 2L there are no RUN beats.
                        state_q <= (N == 2 * L) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (beat_q == RUN_LAST) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (frame_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mod_counter #(.MOD(L)) u_seg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (accept),
        .clr_i  (frame_done),
        .cnt_o  (seg_cnt),
        .wrap_o (seg_wrap)
    );

    mod_counter #(.MOD(ROT_COUNT)) u_sel (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (seg_wrap),
        .clr_i  (frame_done),
        .cnt_o  (sel_cnt),
        .wrap_o (sel_wrap)
    );

    // Segment position and select wrap are not needed beyond the counters.
    assign unused_sig = ^{seg_cnt, sel_wrap};

endmodule

// File: tb/tb_shuffle_ctrl.sv
module tb_shuffle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_sop = 1'b0;
    logic       in_ready;
    logic       buf_en;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;
    logic       busy;
    logic       err_sop;

    int checks = 0;
    int passes = 0;

    // Hand-computed commutator select for beats 0..14 with L=3, N=9.
    logic [1:0] sel_tab [0:14] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2,
                                   2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};

    // {in_ready, buf_en, sel, out_valid, out_sop, out_eop, busy, err_sop}
    localparam logic [8:0] IDLE_VEC = 9'b1_0_00_0_0_0_0_0;

    logic [8:0] exp_v;

    always #5 clk = ~clk;

    shuffle_ctrl #(.L(3), .N(9)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_sop_i    (in_sop),
        .in_ready_o  (in_ready),
        .buf_en_o    (buf_en),
        .sel_o       (sel),
        .out_valid_o (out_valid),
        .out_sop_o   (out_sop),
        .out_eop_o   (out_eop),
        .busy_o      (busy),
        .err_sop_o   (err_sop)
    );

    function automatic logic [8:0] outs();
        return {in_ready, buf_en, sel, out_valid, out_sop, out_eop, busy, err_sop};
    endfunction

    // Drive inputs on the falling edge, let combinational outputs settle.
    task automatic step(input logic r, input logic v, input logic s);
        @(negedge clk);
        rst = r;
        in_valid = v;
        in_sop = s;
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if ({in_ready, buf_en, busy, out_valid} !== 4'b1000)
            $display("FAIL reset_cycle1: got %b want 1000", {in_ready, buf_en, busy, out_valid});
        else passes++;
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (outs() !== IDLE_VEC)
            $display("FAIL reset_cycle2: got %b want %b", outs(), IDLE_VEC);
        else passes++;
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (outs() !== IDLE_VEC)
            $display("FAIL reset_release: got %b want %b", outs(), IDLE_VEC);
        else passes++;
    endtask

    task automatic test_frame();
        int low_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            step(1'b0, c < 9, c == 0);
            if (c < 15) exp_v = {c < 9, 1'b1, sel_tab[c], c >= 6, c == 6, c == 14, c != 0, 1'b0};
            else        exp_v = IDLE_VEC;
            if (!in_ready) low_cnt++;
            checks++;
            if (outs() !== exp_v)
                $display("FAIL frame c=%0d: got %b want %b", c, outs(), exp_v);
            else passes++;
        end
        checks++;
        if (low_cnt !== 6)
            $display("FAIL frame_ready_low: got %0d cycles want 6", low_cnt);
        else passes++;
    endtask

    task automatic test_stall();
        int b;
        for (int c = 0; c < 20; c++) begin
            if (c >= 5 && c <= 8) begin
                step(1'b0, 1'b0, 1'b0);
                exp_v = 9'b1_0_01_0_0_0_1_0;
            end else begin
                b = (c < 5) ? c : c - 4;
                step(1'b0, b < 9, b == 0);
                if (b < 15) exp_v = {b < 9, 1'b1, sel_tab[b], b >= 6, b == 6, b == 14, b != 0, 1'b0};
                else        exp_v = IDLE_VEC;
            end
            checks++;
            if (outs() !== exp_v)
                $display("FAIL stall c=%0d: got %b want %b", c, outs(), exp_v);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        int  b;
        logic hold;
        for (int c = 0; c < 31; c++) begin
            b = (c <= 14) ? c : c - 15;
            hold = (c >= 9 && c <= 15);
            step(1'b0, hold || (b < 9), hold || (c == 0));
            if (b < 15) exp_v = {b < 9, 1'b1, sel_tab[b], b >= 6, b == 6, b == 14, b != 0, 1'b0};
            else        exp_v = IDLE_VEC;
            checks++;
            if (outs() !== exp_v)
                $display("FAIL back_to_back c=%0d: got %b want %b", c, outs(), exp_v);
            else passes++;
        end
    endtask

    task automatic test_mid_sop();
        for (int c = 0; c < 16; c++) begin
            step(1'b0, c < 9, (c == 0) || (c == 5));
            if (c < 15) exp_v = {c < 9, 1'b1, sel_tab[c], c >= 6, c == 6, c == 14, c != 0, c == 5};
            else        exp_v = IDLE_VEC;
            checks++;
            if (outs() !== exp_v)
                $display("FAIL mid_sop c=%0d: got %b want %b", c, outs(), exp_v);
            else passes++;
        end
    endtask

    task automatic test_reset_drain();
        int b;
        for (int c = 0; c < 29; c++) begin
            if (c <= 11) begin
                step(c == 11, c < 9, c == 0);
                if (c < 11) exp_v = {c < 9, 1'b1, sel_tab[c], c >= 6, c == 6, 1'b0, c != 0, 1'b0};
                else        exp_v = {1'b1, 1'b0, sel_tab[11], 5'b0};
            end else if (c == 12) begin
                step(1'b0, 1'b0, 1'b0);
                exp_v = IDLE_VEC;
            end else begin
                b = c - 13;
                step(1'b0, b < 9, b == 0);
                if (b < 15) exp_v = {b < 9, 1'b1, sel_tab[b], b >= 6, b == 6, b == 14, b != 0, 1'b0};
                else        exp_v = IDLE_VEC;
            end
            checks++;
            if (outs() !== exp_v)
                $display("FAIL reset_drain c=%0d: got %b want %b", c, outs(), exp_v);
            else passes++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_back_to_back();
        test_mid_sop();
        test_reset_drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
